// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector and its counters.
package seq_det_pkg;

  localparam int unsigned DEF_PAT_W     = 3;
  localparam int unsigned DEF_CNT_W     = 8;
  localparam logic [31:0] DEF_RESET_PAT = 32'b101;

  // Largest value representable in 'width' bits (width 1..32).
  function automatic logic [31:0] sat_max(input int unsigned width);
    logic [32:0] full;
    full = (33'(1) << width) - 33'(1);
    return full[31:0];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag.
//   clk, reset : clock, synchronous active-high reset
//   inc        : count one event this cycle
//   clr        : clear count and sat (wins over inc)
//   count      : events since reset/clear, stops at 2^CNT_W-1
//   sat        : set when count reaches 2^CNT_W-1
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  // Counter and sticky flag.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
      if (count == CNT_MAX - CNT_W'(1)) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Programmable serial bit-pattern detector, Mealy match output.
//   clk, reset  : clock, synchronous active-high reset
//   pat_load    : load pat_in this cycle (discards din, clears fill)
//   pat_in      : new pattern, MSB is the first bit received
//   overlap     : 1 = overlapping, 0 = non-overlapping detection
//   in_valid    : din is a valid bit this cycle
//   din         : serial data bit
//   count_clr   : clear match_count and count_sat
//   match       : combinational, current valid bit completes the pattern
//   match_count : saturating match counter
//   count_sat   : sticky, set when match_count saturates
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        PAT_W     = DEF_PAT_W,
  parameter logic [PAT_W-1:0]   RESET_PAT = PAT_W'(DEF_RESET_PAT),
  parameter int unsigned        CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             in_valid,
  input  logic             din,
  input  logic             count_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

  logic [PAT_W-1:0]  pat;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window;
  logic              take_bit;

  assign take_bit = in_valid & ~pat_load & ~reset;
  assign window   = {hist, din};
  assign match    = take_bit & (fill == FILL_MAX) & (window == pat);

  // Pattern, history and fill state.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat  <= RESET_PAT;
      hist <= '0;
      fill <= '0;
    end else if (pat_load) begin
      pat  <= pat_in;
      fill <= '0;
    end else if (in_valid) begin
      // Truncating cast drops the oldest bit; also covers PAT_W = 2.
      hist <= (PAT_W-1)'(window);
      if (match && !overlap) begin
        fill <= '0;
      end else if (fill != FILL_MAX) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (match),
    .clr  (count_clr),
    .count(match_count),
    .sat  (count_sat)
  );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: default instance plus a CNT_W=2 twin.
module tb_seq_pattern_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       pat_load;
  logic [2:0] pat_in;
  logic       overlap;
  logic       in_valid;
  logic       din;
  logic       count_clr;

  logic       match;
  logic [7:0] match_count;
  logic       count_sat;
  logic       match2;
  logic [1:0] count2;
  logic       sat2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector dut (
    .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
    .overlap(overlap), .in_valid(in_valid), .din(din), .count_clr(count_clr),
    .match(match), .match_count(match_count), .count_sat(count_sat)
  );

  seq_pattern_detector #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .pat_load(pat_load), .pat_in(pat_in),
    .overlap(overlap), .in_valid(in_valid), .din(din), .count_clr(count_clr),
    .match(match2), .match_count(count2), .count_sat(sat2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One valid bit: check the Mealy output mid-cycle, then clock it in.
  task automatic bit_in(input logic d, input logic exp_m, input string tag);
    in_valid = 1'b1;
    din      = d;
    #1;
    chk(tag, 32'(match), 32'(exp_m));
    @(posedge clk); #1;
    in_valid = 1'b0;
    din      = 1'b0;
  endtask

  task automatic idle(input int n, input string tag);
    in_valid = 1'b0;
    din      = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk(tag, 32'(match), 32'd0);
      @(posedge clk); #1;
    end
    din = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    pat_load  = 1'b0;
    pat_in    = 3'b000;
    overlap   = 1'b1;
    in_valid  = 1'b1;
    din       = 1'b1;
    count_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    chk("rst_sat", 32'(count_sat), 32'd0);
    in_valid = 1'b0;
    reset    = 1'b0;

    // Overlapping: 1,0,1,0,1 matches on bits 3 and 5.
    overlap = 1'b1;
    bit_in(1, 0, "ov_b1"); bit_in(0, 0, "ov_b2"); bit_in(1, 1, "ov_b3");
    bit_in(0, 0, "ov_b4"); bit_in(1, 1, "ov_b5");
    chk("ov_count", 32'(match_count), 32'd2);

    // Non-overlapping: only bit 3 matches.
    do_reset();
    overlap = 1'b0;
    bit_in(1, 0, "nov_b1"); bit_in(0, 0, "nov_b2"); bit_in(1, 1, "nov_b3");
    bit_in(0, 0, "nov_b4"); bit_in(1, 0, "nov_b5");
    chk("nov_count", 32'(match_count), 32'd1);

    // Valid gap does not break a partial match.
    do_reset();
    overlap = 1'b1;
    bit_in(1, 0, "gap_b1"); bit_in(0, 0, "gap_b2");
    idle(4, "gap_idle");
    bit_in(1, 1, "gap_b3");
    chk("gap_count", 32'(match_count), 32'd1);

    // Load 110 partway through "11"; fill restarts, old pattern gone.
    do_reset();
    bit_in(1, 0, "ld_b1"); bit_in(1, 0, "ld_b2");
    pat_load = 1'b1; pat_in = 3'b110;
    bit_in(0, 0, "ld_cycle");
    pat_load = 1'b0;
    bit_in(1, 0, "ld_n1"); bit_in(1, 0, "ld_n2"); bit_in(0, 1, "ld_n3");
    bit_in(1, 0, "ld_o1"); bit_in(0, 0, "ld_o2"); bit_in(1, 0, "ld_o3");
    chk("ld_count", 32'(match_count), 32'd1);

    // pat_load suppresses a bit that would otherwise complete 101.
    do_reset();
    bit_in(1, 0, "lp_b1"); bit_in(0, 0, "lp_b2");
    pat_load = 1'b1; pat_in = 3'b101;
    bit_in(1, 0, "lp_cycle");
    pat_load = 1'b0;
    chk("lp_count0", 32'(match_count), 32'd0);
    bit_in(1, 0, "lp_n1"); bit_in(0, 0, "lp_n2"); bit_in(1, 1, "lp_n3");

    // Saturation on the CNT_W=2 instance.
    do_reset();
    overlap = 1'b1;
    bit_in(1, 0, "sat_b1"); bit_in(0, 0, "sat_b2"); bit_in(1, 1, "sat_m1");
    bit_in(0, 0, "sat_b4"); bit_in(1, 1, "sat_m2");
    chk("sat_c2_at2", 32'(count2), 32'd2);
    chk("sat_flag_at2", 32'(sat2), 32'd0);
    bit_in(0, 0, "sat_b6"); bit_in(1, 1, "sat_m3");
    chk("sat_c2_at3", 32'(count2), 32'd3);
    chk("sat_flag_at3", 32'(sat2), 32'd1);
    bit_in(0, 0, "sat_b8"); bit_in(1, 1, "sat_m4");
    chk("sat_c2_hold", 32'(count2), 32'd3);
    chk("sat_flag_hold", 32'(sat2), 32'd1);
    chk("sat_c8", 32'(match_count), 32'd4);
    chk("sat_c8_flag", 32'(count_sat), 32'd0);

    // count_clr wins over a match in the same cycle.
    bit_in(0, 0, "clr_b1");
    count_clr = 1'b1;
    bit_in(1, 1, "clr_m");
    count_clr = 1'b0;
    chk("clr_c2", 32'(count2), 32'd0);
    chk("clr_sat2", 32'(sat2), 32'd0);
    chk("clr_c8", 32'(match_count), 32'd0);

    // Reset mid-pattern discards history.
    do_reset();
    bit_in(1, 0, "mr_b1"); bit_in(0, 0, "mr_b2");
    reset = 1'b1; in_valid = 1'b1; din = 1'b1;
    #1;
    chk("mr_rst_match", 32'(match), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    bit_in(1, 0, "mr_a1");
    bit_in(1, 0, "mr_a2"); bit_in(0, 0, "mr_a3"); bit_in(1, 1, "mr_a4");
    chk("mr_count", 32'(match_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised, programmable serial bit-pattern detector with a Mealy match output. It is the general successor to the team's fixed 3-bit "101" detector. It adds a run-time loadable pattern of PAT_W bits, selectable overlapping or non-overlapping detection, an input-valid qualifier and a saturating match counter. It sits on a 1-bit serial data path and flags pattern occurrences to downstream control logic in the same cycle the final bit arrives.

## Interface
- PAT_W, 3: pattern length in bits; legal range 2..32.
- RESET_PAT, 3'b101: PAT_W-bit pattern loaded at reset.
- CNT_W, 8: width of the match counter.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- pat_load  in  1  load pat_in into the pattern register this cycle.
- pat_in  in  PAT_W  new pattern; bit PAT_W-1 is the first bit received.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- in_valid  in  1  din carries a valid serial bit this cycle.
- din  in  1  serial data bit.
- count_clr  in  1  clear the match counter and the count_sat flag.
- match  out  1  combinational (Mealy); high when the current valid bit completes the pattern.
- match_count  out  CNT_W  number of matches since reset or clear; saturating.
- count_sat  out  1  sticky; set when match_count reaches 2^CNT_W-1.

## Operation
- State:
  - pattern register pat (PAT_W bits).
  - history shift register hist (PAT_W-1 bits); the newest bit is in the LSB.
  - fill counter fill (0..PAT_W-1), saturating at PAT_W-1.
  - match counter.
- Reset values: pat = RESET_PAT, hist = 0, fill = 0, match_count = 0, count_sat = 0. match = 0 while reset is high.
- match = in_valid & ~pat_load & (fill == PAT_W-1) & ({hist, din} == pat).
- Each cycle with in_valid = 1 and pat_load = 0:
  - hist <= {hist[PAT_W-3:0], din}; for PAT_W = 2, hist <= din.
  - If match and overlap = 0: fill <= 0 and hist keeps shifting, so the last bits cannot start a new match.
  - Otherwise fill <= min(fill+1, PAT_W-1).
- in_valid = 0: hist and fill hold; match = 0. Gaps do not break a partial match.
- pat_load = 1: pat <= pat_in and fill <= 0. Any din in that cycle is discarded and match = 0. pat_load has priority over in_valid.
- overlap is sampled every valid cycle. A change affects only the next match event.
- Counter:
  - On match, match_count increments unless it is already 2^CNT_W-1.
  - count_sat <= 1 when match_count becomes 2^CNT_W-1.
  - count_clr has priority: match_count <= 0 and count_sat <= 0, even if match is high in the same cycle.
- Priority order: reset > pat_load > in_valid; independently, count_clr > counter increment.

## Timing
- Detection latency is 0 cycles: match is high combinationally in the cycle the final bit is presented.
- match_count reflects a match on the next rising edge (1-cycle latency).
- The first possible match is on the PAT_W-th valid bit after reset, pat_load, or a non-overlap match.
- Reset asserted mid-pattern discards all history. A match needs PAT_W fresh valid bits after reset deasserts.
- No handshake back-pressure; the block accepts one bit every cycle.

## Structure
- Shared package seq_det_pkg:
  - default PAT_W, CNT_W and RESET_PAT constants.
  - a function that returns the saturated maximum count for a given width.
- One sub-module, sat_counter (CNT_W, inc, clr → count, sat). The team reuses it for other event counters.
- History, fill and compare logic stay in the top module.

## Test plan
- Reset, PAT_W=3, overlap=1, stream 1,0,1,0,1 → match high on bits 3 and 5; match_count = 2.
- Same stream with overlap=0 → match high on bit 3 only; match_count = 1.
- in_valid low for 4 cycles between bits 2 and 3 of "101" → match still high on the 3rd valid bit; no match during the gap.
- pat_load with pat_in=3'b110 while partway through "11" → fill cleared; stream 1,1,0 → match on the 0; the old pattern "101" no longer matches.
- CNT_W=2, 4 matches → match_count stops at 3 and count_sat = 1. count_clr asserted in the same cycle as a match → count 0, sat 0.
- reset asserted after bits 1,0 of "101", then released; stream 1 → no match; stream 1,0,1 → match.
